// File: rtl/fnn_stream_pkg.sv
// Shared types and default geometry for the pixel-stream transmitter path.
package fnn_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VLEAD,
    LINE,
    HBLANK,
    VTAIL,
    DONE
  } stream_state_t;

  localparam int DEF_COLS       = 28;
  localparam int DEF_ROWS       = 28;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 11;

endpackage

// File: rtl/stream_timing_gen.sv
// Frame/line timing for the pixel stream: VSYNC, HSYNC, row/col counters and
// a fetch strobe that leads each pixel's HSYNC-high cycle by exactly two cycles.
//
// state  | meaning
// IDLE   | waiting for start
// VLEAD  | VSYNC high, before first line (cnt counts down)
// LINE   | HSYNC high, one pixel per cycle (col counts up)
// HBLANK | HSYNC low between lines (cnt counts down)
// VTAIL  | VSYNC high after last line (cnt counts down)
// DONE   | one-cycle frame_done pulse, VSYNC low
module stream_timing_gen
  import fnn_stream_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int V_LEAD  = 4,
  parameter int H_BLANK = 4,
  parameter int V_TAIL  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic frame_done,
  output logic vsync,
  output logic hsync,
  output logic fetch
);

  localparam int CNT_MAX = (V_LEAD > H_BLANK) ? ((V_LEAD > V_TAIL) ? V_LEAD : V_TAIL)
                                              : ((H_BLANK > V_TAIL) ? H_BLANK : V_TAIL);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  stream_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Pixel k is fetched when the pixel two cycles ahead will be on the line.
  // Inside a line that is either the same line (col <= COLS-3) or, when the
  // blank is shorter than two cycles, the first pixels of the next line.
  always_comb begin
    fetch = 1'b0;
    case (state)
      VLEAD:   fetch = (cnt <= CNT_W'(1));
      HBLANK:  fetch = (cnt <= CNT_W'(1));
      LINE:    fetch = (int'(col) <= COLS - 3) ||
                       ((int'(row) != ROWS - 1) && (int'(col) >= COLS + H_BLANK - 2));
      default: fetch = 1'b0;
    endcase
  end

  // Frame sequencer with registered sync/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      vsync      <= 1'b0;
      hsync      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= VLEAD;
            cnt   <= CNT_W'(V_LEAD - 1);
            busy  <= 1'b1;
            vsync <= 1'b1;
          end
        end
        VLEAD: begin
          if (cnt == '0) begin
            state <= LINE;
            col   <= '0;
            row   <= '0;
            hsync <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LINE: begin
          if (col == COL_W'(COLS - 1)) begin
            col <= '0;
            if (row == ROW_W'(ROWS - 1)) begin
              state <= VTAIL;
              cnt   <= CNT_W'(V_TAIL - 1);
              hsync <= 1'b0;
            end else if (H_BLANK == 0) begin
              row <= row + ROW_W'(1);
            end else begin
              state <= HBLANK;
              cnt   <= CNT_W'(H_BLANK - 1);
              hsync <= 1'b0;
            end
          end else begin
            col <= col + COL_W'(1);
          end
        end
        HBLANK: begin
          if (cnt == '0) begin
            state <= LINE;
            row   <= row + ROW_W'(1);
            hsync <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        VTAIL: begin
          if (cnt == '0) begin
            state      <= DONE;
            busy       <= 1'b0;
            vsync      <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_stream_tx.sv
// Streams one ROWS x COLS frame from a synchronous-read frame memory as a
// raster on pixel_out, framed by VSYNC/HSYNC.
// Build option FRAME_STREAM_TX_TEST_PATTERN_EN: pixel_out carries the pixel
// index instead of memory data and the memory is never read; sync timing is
// unchanged.
module frame_stream_tx
  import fnn_stream_pkg::*;
#(
  parameter int dataWidth = DEF_DATA_WIDTH,
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int V_LEAD    = 4,
  parameter int H_BLANK   = 4,
  parameter int V_TAIL    = 3,
  parameter int ADDR_W    = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 mem_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [dataWidth-1:0] mem_rdata,
  output logic [dataWidth-1:0] pixel_out,
  output logic                 HSYNC,
  output logic                 VSYNC
);

  logic fetch;
  logic fetch_d;

  stream_timing_gen #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .V_LEAD  (V_LEAD),
    .H_BLANK (H_BLANK),
    .V_TAIL  (V_TAIL)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .vsync      (VSYNC),
    .hsync      (HSYNC),
    .fetch      (fetch)
  );

`ifdef FRAME_STREAM_TX_TEST_PATTERN_EN
  logic [ADDR_W-1:0] addr_q;
  logic              unused_rdata;

  assign mem_en       = 1'b0;
  assign unused_rdata = ^mem_rdata;

  // Index of the pixel fetched last cycle; becomes pixel_out one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n)     addr_q <= '0;
    else if (fetch) addr_q <= mem_addr;
  end
`else
  assign mem_en = fetch;
`endif

  // Address counter: cleared between frames, advances per fetch, never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || !busy) begin
      mem_addr <= '0;
    end else if (fetch && (mem_addr != ADDR_W'(ROWS * COLS - 1))) begin
      mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

  // Pixel register: loads the read data one cycle after the fetch, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_d   <= 1'b0;
      pixel_out <= '0;
    end else begin
      fetch_d <= fetch;
      if (fetch_d) begin
`ifdef FRAME_STREAM_TX_TEST_PATTERN_EN
        pixel_out <= dataWidth'(addr_q);
`else
        pixel_out <= mem_rdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx: default geometry plus an H_BLANK=0 instance.
module tb_frame_stream_tx;

  localparam int DW     = 16;
  localparam int COLS   = 28;
  localparam int ROWS   = 28;
  localparam int NPIX   = ROWS * COLS;
  localparam int AW     = 10;
  localparam int V_LEAD = 4;
  localparam int V_TAIL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_s, sel;
  logic start0, start1;
  assign start0 = sel ? 1'b0 : start_s;
  assign start1 = sel ? start_s : 1'b0;

  logic          busy0, done0, en0, hs0, vs0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] rdata0, pix0;
  logic          busy1, done1, en1, hs1, vs1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] rdata1, pix1;

  frame_stream_tx #(.H_BLANK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .frame_done(done0),
    .mem_en(en0), .mem_addr(addr0), .mem_rdata(rdata0), .pixel_out(pix0),
    .HSYNC(hs0), .VSYNC(vs0)
  );

  frame_stream_tx #(.H_BLANK(0)) dut_hb0 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .frame_done(done1),
    .mem_en(en1), .mem_addr(addr1), .mem_rdata(rdata1), .pixel_out(pix1),
    .HSYNC(hs1), .VSYNC(vs1)
  );

  logic [DW-1:0] mem [NPIX];

  always @(posedge clk) begin
    if (en0 && int'(addr0) < NPIX) rdata0 <= mem[addr0];
    if (en1 && int'(addr1) < NPIX) rdata1 <= mem[addr1];
  end

  logic          m_busy, m_done, m_en, m_hs, m_vs;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_pix;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_en   = sel ? en1   : en0;
  assign m_hs   = sel ? hs1   : hs0;
  assign m_vs   = sel ? vs1   : vs0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_pix  = sel ? pix1  : pix0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_pix_q [$];
  logic [AW-1:0] exp_addr_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference line structure: after V_LEAD cycles, lines of COLS pixels with hb gaps.
  function automatic bit model_hsync(input int c, input int hb);
    int p;
    int period;
    p      = c - V_LEAD - 1;
    period = COLS + hb;
    if (p < 0) return 1'b0;
    if (p / period >= ROWS) return 1'b0;
    return (p % period) < COLS;
  endfunction

  task automatic push_frame();
    for (int k = 0; k < NPIX; k++) begin
`ifdef FRAME_STREAM_TX_TEST_PATTERN_EN
      exp_pix_q.push_back(DW'(k));
`else
      exp_pix_q.push_back(mem[k]);
`endif
      exp_addr_q.push_back(AW'(k));
    end
  endtask

  // One frame from a start pulse; optional mid-frame start or reset at cycle index.
  task automatic run_frame(input int hb, input int restart_at, input int abort_at);
    int total_v;
    int n_done;
    int n_en;
    bit seen_pix;
    logic [DW-1:0] last_pix;
    logic [DW-1:0] ep;
    logic [AW-1:0] ea;
    total_v  = V_LEAD + NPIX + (ROWS - 1) * hb + V_TAIL;
    n_done   = 0;
    n_en     = 0;
    seen_pix = 1'b0;
    last_pix = '0;
    push_frame();
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int c = 1; c <= total_v + 2; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", m_busy, 0);
        check("rst_frame_done", m_done, 0);
        check("rst_mem_en", m_en, 0);
        check("rst_hsync", m_hs, 0);
        check("rst_vsync", m_vs, 0);
        check("rst_mem_addr", m_addr, 0);
        check("rst_pixel", m_pix, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pix_q.delete();
        exp_addr_q.delete();
        return;
      end
      check("vsync", m_vs, c <= total_v);
      check("busy", m_busy, c <= total_v);
      check("frame_done", m_done, c == total_v + 1);
      if (m_done) n_done++;
      check("hsync", m_hs, model_hsync(c, hb));
`ifdef FRAME_STREAM_TX_TEST_PATTERN_EN
      check("mem_en_off", m_en, 0);
`else
      check("mem_en", m_en, model_hsync(c + 2, hb));
      if (m_en) begin
        n_en++;
        if (exp_addr_q.size() == 0) check("addr_extra", 1, 0);
        else begin
          ea = exp_addr_q.pop_front();
          check("mem_addr", m_addr, ea);
        end
      end
`endif
      if (m_hs) begin
        if (exp_pix_q.size() == 0) check("pixel_extra", 1, 0);
        else begin
          ep = exp_pix_q.pop_front();
          check("pixel", m_pix, ep);
          last_pix = ep;
          seen_pix = 1'b1;
        end
      end else if (seen_pix) begin
        check("pixel_hold", m_pix, last_pix);
      end
      start_s = (c == restart_at);
    end
    start_s = 1'b0;
    check("frame_done_count", n_done, 1);
    check("pixels_left", exp_pix_q.size(), 0);
`ifndef FRAME_STREAM_TX_TEST_PATTERN_EN
    check("mem_en_count", n_en, NPIX);
    check("addrs_left", exp_addr_q.size(), 0);
`endif
    exp_pix_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    int waited;
    sel     = 1'b0;
    rst_n   = 1'b0;
    start_s = 1'b0;
`ifndef FRAME_STREAM_TX_TEST_PATTERN_EN
    for (int k = 0; k < NPIX; k++) mem[k] = DW'(k);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", m_busy, 0);
    check("reset_vsync", m_vs, 0);
    check("reset_hsync", m_hs, 0);
    check("reset_mem_addr", m_addr, 0);
    check("reset_pixel", m_pix, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame, default geometry.
    run_frame(4, -1, -1);

    // Start during a frame is ignored; a later start gives an identical frame.
    run_frame(4, 200, -1);
    repeat (5) begin
      @(negedge clk);
      check("idle_no_done", m_done, 0);
      check("idle_not_busy", m_busy, 0);
    end
    run_frame(4, -1, -1);

    // Reset during row 10, then a complete frame from pixel 0.
    run_frame(4, -1, V_LEAD + 10 * (COLS + 4) + 6);
    run_frame(4, -1, -1);

    // No horizontal blanking.
    sel = 1'b1;
    run_frame(0, -1, -1);
    sel = 1'b0;

    // start held high: DONE, one IDLE cycle, then the next frame.
    @(negedge clk);
    start_s = 1'b1;
    waited  = 0;
    while (!m_done && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_first_done_seen", m_done, 1);
    @(negedge clk);
    check("b2b_idle_vsync", m_vs, 0);
    check("b2b_idle_busy", m_busy, 0);
    @(negedge clk);
    check("b2b_restart_vsync", m_vs, 1);
    check("b2b_restart_busy", m_busy, 1);
    start_s = 1'b0;
    waited  = 0;
    while (!m_done && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_second_done_seen", m_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_stream_tx.md
Name: frame_stream_tx

Overview:
Transmitter side of the pixel-stream interface consumed by stream_neural_net. It reads one ROWS x COLS image of fixed-point pixels from a synchronous-read frame memory and emits it as a raster stream on pixel_out, framed by VSYNC and HSYNC. It replaces bench-driven stimulus in on-board builds and sits between the image buffer (BRAM or camera capture) and the network input.

Parameters:
dataWidth, 16, pixel width; Q(dataWidth-frac_bits).frac_bits, matching the net.
COLS, 28, pixels per line.
ROWS, 28, lines per frame.
V_LEAD, 4, cycles VSYNC=1 before the first line; must be >= 2 (covers prefetch).
H_BLANK, 4, cycles HSYNC=0 between lines; 0 is legal.
V_TAIL, 3, cycles VSYNC=1 after the last line.
ADDR_W, $clog2(ROWS*COLS), frame memory address width.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  request one frame; sampled only in IDLE.
busy  out  1  high from the cycle after start is accepted until frame_done.
frame_done  out  1  one-cycle pulse after VSYNC falls.
mem_en  out  1  frame memory read enable.
mem_addr  out  ADDR_W  pixel index, row*COLS+col.
mem_rdata  in  dataWidth  read data, valid one cycle after mem_en/mem_addr.
pixel_out  out  dataWidth  registered pixel; connects to the net's in.
HSYNC  out  1  high exactly while a line's pixels are on pixel_out.
VSYNC  out  1  high for the whole frame window.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy, frame_done, mem_en, HSYNC, VSYNC = 0; mem_addr = 0; pixel_out = 0; all counters 0. Reset mid-frame aborts immediately. No frame_done is produced, and the next frame starts from pixel 0.
- FSM states: IDLE -> VLEAD -> LINE -> (HBLANK -> LINE)* -> VTAIL -> DONE -> IDLE.
- IDLE: start=1 at edge T moves to VLEAD. busy=1 and VSYNC=1 from T+1.
- VLEAD: V_LEAD cycles, VSYNC=1, HSYNC=0.
- LINE: COLS cycles, HSYNC=1, pixel_out = pixel row*COLS+col, col incrementing each cycle.
- HBLANK: H_BLANK cycles, HSYNC=0, pixel_out holds its last value. HBLANK is skipped after the final row, and skipped entirely when H_BLANK=0 (HSYNC stays high across lines).
- VTAIL: V_TAIL cycles, VSYNC=1, HSYNC=0.
- DONE: one cycle with VSYNC=0, frame_done=1, busy=0. Then IDLE.
- Total cycles with VSYNC high: V_LEAD + ROWS*COLS + (ROWS-1)*H_BLANK + V_TAIL.
- Prefetch: the address for pixel k is presented with mem_en=1 exactly 2 cycles before pixel k's HSYNC-high cycle. mem_rdata is captured into pixel_out on the following edge. mem_en=0 in every other cycle.
- Each address is issued exactly once per frame, in order 0 .. ROWS*COLS-1. No address wraps past ROWS*COLS-1.
- start while busy is ignored, with no queuing. start held high continuously yields back-to-back frames separated by the single DONE cycle plus one IDLE cycle.

Optional Feature:
Macro FRAME_STREAM_TX_TEST_PATTERN_EN.
- Defined: mem_en stays 0. pixel_out = pixel index k, zero-extended/truncated to dataWidth, with identical timing.
- Undefined: memory-sourced pixels as above.
- Sync timing is identical in both cases.

Decomposition:
- Shared package fnn_stream_pkg: state enum typedef (IDLE, VLEAD, LINE, HBLANK, VTAIL, DONE), default geometry constants (28, 28), default dataWidth/frac_bits (16/11).
- One sub-module, stream_timing_gen: generates VSYNC, HSYNC, row and col counters, and the prefetch strobe from the geometry parameters.
- The top level adds the address counter, memory interface and pixel register.

Test Plan:
1. Defaults, memory preloaded with mem[k]=k, start pulse at T -> VSYNC high T+1 .. T+899; first HSYNC rise at T+5; pixel_out 0..27 on line 0; 28 HSYNC-high runs of 28 cycles separated by 4-cycle gaps; frame_done at T+900.
2. Same frame -> mem_addr sequence 0..783, each issued once and exactly 2 cycles before its pixel; mem_en high 784 cycles total.
3. H_BLANK=0 -> HSYNC high for 784 consecutive cycles; pixel_out 0..783 contiguous; VSYNC high 791 cycles.
4. start pulsed again mid-frame -> ignored; exactly one frame_done; second start after DONE -> a new identical frame.
5. rst_n=0 for 1 cycle during row 10 -> next edge shows all outputs 0 and state IDLE; following start -> pixel 0 first, full 899-cycle frame.
6. FRAME_STREAM_TX_TEST_PATTERN_EN defined, memory uninitialized -> pixel_out 0..783 with identical sync timing; mem_en never asserted.
